mmb_burst_arbiter: RTL and testbench

- Shares one MemoryMapped burst master port (Avalon-MM style: address, burstcount, write, writedata, read, readdata, readdatavalid, waitrequest) between two requesters, e.g. two ds_mmb_buffer instances on one memory.
- Arbitrates round-robin at burst granularity and never interleaves words of different write bursts.
- Tracks outstanding reads in a tag FIFO so read data returns only to the requester that issued the read.

---
 rtl/mmb_burst_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mmb_burst_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmb_burst_arbiter.sv
// mmb_burst_arbiter
//
// Shares one Avalon-MM style burst master port between two requesters.
// Arbitration is round-robin at burst granularity: once a requester wins,
// it owns the memory port for a whole write burst (never interleaved with
// the other requester) or for a single read command. Outstanding reads are
// remembered in a small tag FIFO so the returning data words are steered
// only to the requester that issued the read.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   sN_addr, sN_bcnt    requester N burst start address / burst length
//   sN_wreq, sN_wdat    requester N write request / write data
//   sN_rreq             requester N read request
//   sN_rdat, sN_rval    requester N read data / read data valid
//   sN_busy             requester N waitrequest
//   m_addr, m_bcnt      memory burst start address / burst length
//   m_wreq, m_wdat      memory write / write data
//   m_rreq              memory read
//   m_rdat, m_rval      memory read data / read data valid
//   m_busy              memory waitrequest
module mmb_burst_arbiter #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 6,
    parameter int BWIDTH = 4,
    parameter int TDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] s0_addr,
    input  logic [BWIDTH-1:0] s0_bcnt,
    input  logic              s0_wreq,
    input  logic [DWIDTH-1:0] s0_wdat,
    input  logic              s0_rreq,
    output logic [DWIDTH-1:0] s0_rdat,
    output logic              s0_rval,
    output logic              s0_busy,
    input  logic [AWIDTH-1:0] s1_addr,
    input  logic [BWIDTH-1:0] s1_bcnt,
    input  logic              s1_wreq,
    input  logic [DWIDTH-1:0] s1_wdat,
    input  logic              s1_rreq,
    output logic [DWIDTH-1:0] s1_rdat,
    output logic              s1_rval,
    output logic              s1_busy,
    output logic [AWIDTH-1:0] m_addr,
    output logic [BWIDTH-1:0] m_bcnt,
    output logic              m_wreq,
    output logic [DWIDTH-1:0] m_wdat,
    output logic              m_rreq,
    input  logic [DWIDTH-1:0] m_rdat,
    input  logic              m_rval,
    input  logic              m_busy
);

    localparam int PW = $clog2(TDEPTH);
    localparam logic [BWIDTH-1:0] BONE = BWIDTH'(1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    // A burst count of zero still moves one word.
    function automatic logic [BWIDTH-1:0] burst_len(input logic [BWIDTH-1:0] b);
        return (b == '0) ? BONE : b;
    endfunction

    state_t            state, state_nxt;
    logic              gnt_id, gnt_id_nxt;    // requester owning the port
    logic              last_id, last_id_nxt;  // round-robin pointer (last winner)
    logic [BWIDTH-1:0] wcnt, wcnt_nxt;        // write words still to accept

    // Grantee-selected request fields
    logic [AWIDTH-1:0] g_addr;
    logic [BWIDTH-1:0] g_bcnt;
    logic              g_wreq;
    logic              g_rreq;
    logic [DWIDTH-1:0] g_wdat;
    logic              g_busy;

    // Arbitration candidates
    logic              p0, p1;
    logic              pick;
    logic              pick_wreq;
    logic [BWIDTH-1:0] pick_bcnt;

    // Tag FIFO: one entry per accepted read command
    logic              tag_id_mem   [TDEPTH];
    logic [BWIDTH-1:0] tag_bcnt_mem [TDEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              tag_full, tag_empty;
    logic              tag_push, tag_pop;
    logic              head_id;
    logic [BWIDTH-1:0] head_bcnt;

    // Read return tracking
    logic [BWIDTH-1:0] ret_cnt;   // 0 = head burst not started yet
    logic [BWIDTH-1:0] ret_rem;
    logic              ret_take;

    always_comb begin
        g_addr = gnt_id ? s1_addr : s0_addr;
        g_bcnt = gnt_id ? s1_bcnt : s0_bcnt;
        g_wreq = gnt_id ? s1_wreq : s0_wreq;
        g_rreq = gnt_id ? s1_rreq : s0_rreq;
        g_wdat = gnt_id ? s1_wdat : s0_wdat;
    end

    // s0 wins a tie only when s1 was the last winner.
    always_comb begin
        p0        = s0_wreq | s0_rreq;
        p1        = s1_wreq | s1_rreq;
        pick      = !(p0 && (!p1 || last_id));
        pick_wreq = pick ? s1_wreq : s0_wreq;
        pick_bcnt = pick ? s1_bcnt : s0_bcnt;
    end

    always_comb begin
        tag_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        tag_empty = (wr_ptr == rd_ptr);
        head_id   = tag_id_mem[rd_ptr[PW-1:0]];
        head_bcnt = tag_bcnt_mem[rd_ptr[PW-1:0]];
    end

    always_comb begin
        state_nxt   = state;
        gnt_id_nxt  = gnt_id;
        last_id_nxt = last_id;
        wcnt_nxt    = wcnt;
        m_wreq      = 1'b0;
        m_rreq      = 1'b0;
        g_busy      = 1'b1;
        tag_push    = 1'b0;
        case (state)
            IDLE: begin
                if (p0 || p1) begin
                    gnt_id_nxt  = pick;
                    last_id_nxt = pick;
                    if (pick_wreq) begin
                        state_nxt = WR;
                        wcnt_nxt  = burst_len(pick_bcnt);
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                // A full tag FIFO stalls the read even if a pop is in flight,
                // so the push never has to rely on the same-cycle pop.
                m_rreq = g_rreq & ~tag_full;
                g_busy = m_busy | tag_full;
                if (!g_rreq) begin
                    state_nxt = IDLE;
                end else if (m_rreq && !m_busy) begin
                    tag_push  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR: begin
                m_wreq = g_wreq;
                g_busy = m_busy;
                if (g_wreq && !m_busy) begin
                    wcnt_nxt = wcnt - BONE;
                    if (wcnt == BONE) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ret_rem  = (ret_cnt == '0) ? burst_len(head_bcnt) : ret_cnt;
        ret_take = m_rval & ~tag_empty;     // data with no owner is dropped
        tag_pop  = ret_take & (ret_rem == BONE);
    end

    assign m_addr  = g_addr;
    assign m_bcnt  = g_bcnt;
    assign m_wdat  = g_wdat;
    assign s0_busy = gnt_id ? 1'b1 : g_busy;
    assign s1_busy = gnt_id ? g_busy : 1'b1;
    assign s0_rdat = m_rdat;
    assign s1_rdat = m_rdat;
    assign s0_rval = ret_take & ~head_id;
    assign s1_rval = ret_take & head_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt_id  <= 1'b0;
            last_id <= 1'b1;
            wcnt    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ret_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gnt_id  <= gnt_id_nxt;
            last_id <= last_id_nxt;
            wcnt    <= wcnt_nxt;
            wr_ptr  <= wr_ptr + (PW+1)'(tag_push);
            rd_ptr  <= rd_ptr + (PW+1)'(tag_pop);
            if (ret_take) ret_cnt <= tag_pop ? '0 : ret_rem - BONE;
        end
    end

    // Tag storage holds payload only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_id_mem[wr_ptr[PW-1:0]]   <= gnt_id;
            tag_bcnt_mem[wr_ptr[PW-1:0]] <= g_bcnt;
        end
    end

endmodule

// File: tb/tb_mmb_burst_arbiter.sv
`timescale 1ns/1ps
module tb_mmb_burst_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] s0_addr = '0, s1_addr = '0;
    logic [3:0] s0_bcnt = '0, s1_bcnt = '0;
    logic       s0_wreq = 1'b0, s1_wreq = 1'b0;
    logic [7:0] s0_wdat = '0, s1_wdat = '0;
    logic       s0_rreq = 1'b0, s1_rreq = 1'b0;
    logic [7:0] s0_rdat, s1_rdat;
    logic       s0_rval, s1_rval, s0_busy, s1_busy;
    logic [5:0] m_addr;
    logic [3:0] m_bcnt;
    logic       m_wreq, m_rreq;
    logic [7:0] m_wdat;
    logic [7:0] m_rdat_r = '0;
    logic       m_rval_r = 1'b0;
    logic       mbusy = 1'b0;

    mmb_burst_arbiter #(.DWIDTH(8), .AWIDTH(6), .BWIDTH(4), .TDEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .s0_addr(s0_addr), .s0_bcnt(s0_bcnt), .s0_wreq(s0_wreq), .s0_wdat(s0_wdat),
        .s0_rreq(s0_rreq), .s0_rdat(s0_rdat), .s0_rval(s0_rval), .s0_busy(s0_busy),
        .s1_addr(s1_addr), .s1_bcnt(s1_bcnt), .s1_wreq(s1_wreq), .s1_wdat(s1_wdat),
        .s1_rreq(s1_rreq), .s1_rdat(s1_rdat), .s1_rval(s1_rval), .s1_busy(s1_busy),
        .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat),
        .m_rreq(m_rreq), .m_rdat(m_rdat_r), .m_rval(m_rval_r), .m_busy(mbusy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model (RDLATENCY = 5) ----------------
    typedef struct { logic [7:0] d; int rdy; } rw_t;
    logic [7:0] mem [64];
    rw_t        rq[$];
    int         glog[$];        // requester owning each accepted write burst
    int         cyc = 0;
    int         wb_idx = 0;
    int         wb_len = 1;
    logic [5:0] wb_addr = '0;
    int         wr_words = 0;
    bit         hold_rval = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_idx   <= 0;
            m_rval_r <= 1'b0;
            rq.delete();
        end else begin
            cyc <= cyc + 1;
            if (m_wreq && !mbusy) begin
                wr_words <= wr_words + 1;
                if (wb_idx == 0) begin
                    glog.push_back(s0_busy ? 1 : 0);
                    mem[m_addr] <= m_wdat;
                    wb_addr     <= m_addr;
                    wb_len      <= (m_bcnt == 0) ? 1 : int'(m_bcnt);
                    wb_idx      <= (m_bcnt <= 1) ? 0 : 1;
                end else begin
                    mem[wb_addr + 6'(wb_idx)] <= m_wdat;
                    wb_idx <= (wb_idx + 1 == wb_len) ? 0 : wb_idx + 1;
                end
            end
            if (m_rreq && !mbusy) begin
                for (int k = 0; k < ((m_bcnt == 0) ? 1 : int'(m_bcnt)); k++)
                    rq.push_back('{mem[m_addr + 6'(k)], cyc + 5 + k});
            end
            if (!hold_rval && rq.size() > 0 && rq[0].rdy <= cyc) begin
                m_rval_r <= 1'b1;
                m_rdat_r <= rq[0].d;
                void'(rq.pop_front());
            end else begin
                m_rval_r <= 1'b0;
            end
        end
    end

    // ---------------- read return monitor ----------------
    logic [7:0] rx0[$], rx1[$];
    int         rxw[$];
    int         dropped = 0;

    always @(negedge clk) begin
        if (s0_rval) begin rx0.push_back(s0_rdat); rxw.push_back(0); end
        if (s1_rval) begin rx1.push_back(s1_rdat); rxw.push_back(1); end
        if (m_rval_r && (s0_rval == s1_rval)) dropped <= dropped + 1;
    end

    // ---------------- drivers ----------------
    task automatic drive_w(input int id, input logic w, input logic [5:0] a,
                           input logic [3:0] b, input logic [7:0] d);
        if (id == 0) begin s0_wreq = w; s0_addr = a; s0_bcnt = b; s0_wdat = d; end
        else         begin s1_wreq = w; s1_addr = a; s1_bcnt = b; s1_wdat = d; end
    endtask

    task automatic drive_r(input int id, input logic r, input logic [5:0] a, input logic [3:0] b);
        if (id == 0) begin s0_rreq = r; s0_addr = a; s0_bcnt = b; end
        else         begin s1_rreq = r; s1_addr = a; s1_bcnt = b; end
    endtask

    function automatic logic busy_of(input int id);
        return (id == 0) ? s0_busy : s1_busy;
    endfunction

    task automatic do_write(input int id, input logic [5:0] a, input logic [3:0] b,
                            input logic [7:0] d0, input int words, input bit bubble, input bit rel);
        int n = 0;
        int c = 0;
        while (n < words && c < 200) begin
            @(negedge clk);
            drive_w(id, 1'b1, a, b, 8'(d0 + 8'(n)));
            #1;
            if (bubble && c == 0) begin
                check("wr_bubble_busy", busy_of(id), 1);
                check("wr_bubble_mwreq", m_wreq, 0);
            end
            if (!busy_of(id)) begin
                check("wr_m_wreq", m_wreq, 1);
                check("wr_m_addr", m_addr, a);
                check("wr_m_bcnt", m_bcnt, b);
                check("wr_m_wdat", m_wdat, 8'(d0 + 8'(n)));
                check("wr_other_busy", busy_of(1 - id), 1);
                n++;
            end
            c++;
        end
        if (n < words) check("wr_timeout", n, words);
        if (rel) begin
            @(negedge clk);
            drive_w(id, 1'b0, a, b, d0);
        end
    endtask

    task automatic do_read(input int id, input logic [5:0] a, input logic [3:0] b);
        int c = 0;
        bit acc = 1'b0;
        while (!acc && c < 100) begin
            @(negedge clk);
            drive_r(id, 1'b1, a, b);
            #1;
            if (!busy_of(id)) begin
                check("rd_m_rreq", m_rreq, 1);
                check("rd_m_addr", m_addr, a);
                check("rd_m_bcnt", m_bcnt, b);
                check("rd_m_wreq", m_wreq, 0);
                acc = 1'b1;
            end
            c++;
        end
        if (!acc) check("rd_timeout", 0, 1);
        @(negedge clk);
        drive_r(id, 1'b0, a, b);
    endtask

    // ---------------- vector tables ----------------
    typedef struct { int id; logic [5:0] addr; logic [3:0] bcnt; logic [7:0] d0; int words; } wvec_t;
    typedef struct { int id; logic [5:0] addr; logic [3:0] bcnt; int words; logic [31:0] exp; } rvec_t;
    wvec_t wv[5];
    rvec_t rv[4];

    initial begin
        int gbase, base0, base1, basew, prev, c, n, i0, i1;
        bit acc;
        logic [7:0] exp_alt [8];

        wv[0] = '{0, 6'h10, 4'd4,  8'h01, 4};
        wv[1] = '{1, 6'h20, 4'd2,  8'h21, 2};
        wv[2] = '{0, 6'h00, 4'd3,  8'h30, 3};
        wv[3] = '{1, 6'h08, 4'd0,  8'h55, 1};
        wv[4] = '{1, 6'h30, 4'd15, 8'h60, 15};
        rv[0] = '{0, 6'h00, 4'd3, 3, 32'h0032_3130};
        rv[1] = '{1, 6'h20, 4'd2, 2, 32'h0000_2221};
        rv[2] = '{1, 6'h08, 4'd0, 1, 32'h0000_0055};
        rv[3] = '{0, 6'h10, 4'd4, 4, 32'h0403_0201};
        exp_alt = '{8'h90, 8'h91, 8'h94, 8'h95, 8'hA0, 8'hA1, 8'hA4, 8'hA5};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_s0_busy", s0_busy, 1);
        check("rst_s1_busy", s1_busy, 1);
        check("rst_m_wreq", m_wreq, 0);
        check("rst_m_rreq", m_rreq, 0);
        check("rst_s0_rval", s0_rval, 0);
        check("rst_s1_rval", s1_rval, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_s0_busy", s0_busy, 1);

        // Table-driven single write bursts
        for (int i = 0; i < 5; i++) begin
            do_write(wv[i].id, wv[i].addr, wv[i].bcnt, wv[i].d0, wv[i].words, 1'b1, 1'b1);
            #1;
            check("wr_end_idle_busy", busy_of(wv[i].id), 1);
            check("wr_end_m_wreq", m_wreq, 0);
        end
        check("mem_10", mem[6'h10], 8'h01);
        check("mem_13", mem[6'h13], 8'h04);
        check("mem_3e", mem[6'h3E], 8'h6E);

        // Both requesters holding 2-word writes: grants alternate
        gbase = glog.size();
        fork
            begin
                do_write(0, 6'h38, 4'd2, 8'h90, 2, 1'b0, 1'b0);
                do_write(0, 6'h3A, 4'd2, 8'h94, 2, 1'b0, 1'b1);
            end
            begin
                do_write(1, 6'h3C, 4'd2, 8'hA0, 2, 1'b0, 1'b0);
                do_write(1, 6'h3E, 4'd2, 8'hA4, 2, 1'b0, 1'b1);
            end
        join
        check("alt_grant_count", glog.size() - gbase, 4);
        for (int k = 0; k < 4; k++)
            if (gbase + k < glog.size()) check("alt_grant_order", glog[gbase + k], k % 2);
        for (int k = 0; k < 8; k++)
            check("alt_mem", mem[6'h38 + 6'(k)], exp_alt[k]);

        // Table-driven reads, issued back to back
        base0 = rx0.size(); base1 = rx1.size(); basew = rxw.size();
        for (int i = 0; i < 4; i++) do_read(rv[i].id, rv[i].addr, rv[i].bcnt);
        repeat (40) @(negedge clk);
        i0 = base0; i1 = base1; n = basew;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < rv[i].words; k++) begin
                if (n < rxw.size()) check("rd_order_id", rxw[n], rv[i].id);
                else check("rd_order_missing", 0, 1);
                n++;
                if (rv[i].id == 0) begin
                    if (i0 < rx0.size()) check("rd_s0_data", rx0[i0], rv[i].exp[8*k +: 8]);
                    i0++;
                end else begin
                    if (i1 < rx1.size()) check("rd_s1_data", rx1[i1], rv[i].exp[8*k +: 8]);
                    i1++;
                end
            end
        end
        check("rd_s0_pulses", rx0.size() - base0, 7);
        check("rd_s1_pulses", rx1.size() - base1, 3);

        // Tag FIFO full: 4 reads held, 5th waits for first burst to return
        hold_rval = 1'b1;
        base0 = rx0.size();
        for (int i = 0; i < 4; i++) do_read(0, 6'h10, 4'd2);
        prev = rx0.size(); c = 0; acc = 1'b0;
        while (!acc && c < 60) begin
            @(negedge clk);
            if (c == 6) hold_rval = 1'b0;
            drive_r(0, 1'b1, 6'h10, 4'd2);
            #1;
            if (!s0_busy) begin
                check("full_m_rreq", m_rreq, 1);
                check("full_pop_before_accept", (prev - base0) >= 2, 1);
                acc = 1'b1;
            end else if (c < 6) begin
                check("full_s0_busy", s0_busy, 1);
                check("full_m_rreq_low", m_rreq, 0);
            end
            prev = rx0.size();
            c++;
        end
        if (!acc) check("full_timeout", 0, 1);
        @(negedge clk);
        drive_r(0, 1'b0, 6'h10, 4'd2);
        repeat (30) @(negedge clk);
        check("full_total_words", rx0.size() - base0, 10);
        for (int k = 0; k < 10; k++)
            if (base0 + k < rx0.size()) check("full_data", rx0[base0 + k], (k % 2) + 1);

        // Random m_busy with s1 mid 8-word write; s0 locked out
        gbase = glog.size(); basew = wr_words; n = 0; c = 0;
        while (n < 8 && c < 300) begin
            @(negedge clk);
            mbusy = 1'($urandom_range(0, 1));
            drive_w(1, 1'b1, 6'h28, 4'd8, 8'(8'h80 + 8'(n)));
            if (c == 2) drive_w(0, 1'b1, 6'h27, 4'd1, 8'hEE);
            #1;
            if (c >= 1) check("rb_s0_locked", s0_busy, 1);
            if (!s1_busy) begin
                check("rb_m_bcnt", m_bcnt, 8);
                check("rb_m_wdat", m_wdat, 8'(8'h80 + 8'(n)));
                n++;
            end
            c++;
        end
        if (n < 8) check("rb_timeout", n, 8);
        @(negedge clk);
        drive_w(1, 1'b0, 6'h28, 4'd8, 8'h80);
        mbusy = 1'b0;
        check("rb_wreq_word_cnt", wr_words - basew, 8);
        do_write(0, 6'h27, 4'd1, 8'hEE, 1, 1'b0, 1'b1);
        check("rb_grant_count", glog.size() - gbase, 2);
        if (glog.size() >= gbase + 2) begin
            check("rb_first_grant_s1", glog[gbase], 1);
            check("rb_then_s0", glog[gbase + 1], 0);
        end
        check("rb_mem_2f", mem[6'h2F], 8'h87);
        check("rb_mem_27", mem[6'h27], 8'hEE);

        // Reset at word 2 of a 4-word write
        n = 0; c = 0;
        while (n < 1 && c < 20) begin
            @(negedge clk);
            drive_w(0, 1'b1, 6'h04, 4'd4, 8'hA0);
            #1;
            if (!s0_busy) n++;
            c++;
        end
        @(negedge clk);
        drive_w(0, 1'b1, 6'h04, 4'd4, 8'hA1);
        #1;
        check("mid_pre_rst_granted", s0_busy, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_m_wreq", m_wreq, 0);
        check("mid_rst_s0_busy", s0_busy, 1);
        check("mid_rst_s1_busy", s1_busy, 1);
        @(negedge clk);
        reset = 1'b0;
        drive_w(0, 1'b0, 6'h04, 4'd4, 8'hA1);
        gbase = glog.size();
        fork
            do_write(0, 6'h04, 4'd4, 8'hB0, 4, 1'b0, 1'b1);
            do_write(1, 6'h0C, 4'd1, 8'hC0, 1, 1'b0, 1'b1);
        join
        #1;
        check("post_rst_s0_idle", s0_busy, 1);
        if (glog.size() >= gbase + 2) begin
            check("post_rst_rr_s0_first", glog[gbase], 0);
            check("post_rst_then_s1", glog[gbase + 1], 1);
        end else check("post_rst_grants", glog.size() - gbase, 2);
        for (int k = 0; k < 4; k++) check("post_rst_mem", mem[6'h04 + 6'(k)], 8'hB0 + 8'(k));
        check("post_rst_mem_0c", mem[6'h0C], 8'hC0);

        check("no_dropped_rval", dropped, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
